reg_write_arbiter: RTL and testbench

Round-robin write arbiter for a shared 16-bit load-enabled register (reg16: clk, load, vecin, vecout).
- Up to NREQ requesters (control unit, ALU writeback, memory load path, debug) compete for the register's single write port.
- Block drives the register's load and vecin from registered outputs.
- Supports locked bursts bounded by MAX_BURST so no requester is starved.

---
 rtl/reg_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin write arbiter that owns the single write port of a shared
// load-enabled register (reg16: load / vecin). Each cycle it picks one of
// NREQ requesters and drives the register's load and data from registered
// outputs. A requester holding lock may keep the port for up to MAX_BURST
// consecutive writes. After that it is forced to release for one arbitration.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester write request (level, held until gnt seen)
//   lock     per-requester burst request, only meaningful together with req
//   wdata    requester i data at [i*WIDTH +: WIDTH]
//   gnt      registered one-hot grant, high in the cycle the write happens
//   reg_load register load strobe (OR of gnt)
//   reg_din  register data, registered copy of the winner's wdata
//   owner    index of the most recent winner, holds while idle
module reg_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic                      reg_load,
    output logic [WIDTH-1:0]          reg_din,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    // Last burst count at which the owner may still be regranted.
    localparam logic [BW-1:0]   BURST_LIM = BW'(MAX_BURST - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   gnt_nxt_s;
    logic              reg_load_r;
    logic              reg_load_nxt_s;
    logic [WIDTH-1:0]  reg_din_r;
    logic [WIDTH-1:0]  reg_din_nxt_s;
    logic [IW-1:0]     owner_r;
    logic [IW-1:0]     owner_nxt_s;
    logic [IW-1:0]     ptr_r;
    logic [IW-1:0]     ptr_nxt_s;
    logic [BW-1:0]     burst_cnt_r;
    logic [BW-1:0]     burst_cnt_nxt_s;

    logic              cont_s;
    logic [NREQ-1:0]   elig_s;
    logic              found_s;
    logic [IW-1:0]     winner_s;
    logic [IW-1:0]     cand_s;
    logic [IW-1:0]     sel_idx_s;

    // Lock continuation: the current owner keeps the port while it still
    // requests with lock and has burst budget left.
    always_comb begin
        cont_s = 1'b0;
        if (state_r == GRANT) begin
            cont_s = lock[owner_r] & req[owner_r] & (burst_cnt_r < BURST_LIM);
        end else begin
            cont_s = 1'b0;
        end
    end

    // Eligibility mask: the owner just written is excluded, so a stale req
    // after its grant can never produce a back-to-back duplicate write.
    always_comb begin
        elig_s = req;
        case (state_r)
            GRANT:   elig_s[owner_r] = 1'b0;
            IDLE:    elig_s = req;
            default: elig_s = req;
        endcase
    end

    // Round-robin search: first eligible index at or after ptr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IW{1'b0}};
        cand_s   = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr_r) + k) % NREQ);
            if (!found_s && elig_s[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Data mux index: a lock regrant re-selects the owner.
    always_comb begin
        if (cont_s) begin
            sel_idx_s = owner_r;
        end else begin
            sel_idx_s = winner_s;
        end
    end

    // Next-state and next-output logic of the IDLE/GRANT machine.
    always_comb begin
        state_nxt_s     = IDLE;
        gnt_nxt_s       = {NREQ{1'b0}};
        reg_load_nxt_s  = 1'b0;
        reg_din_nxt_s   = reg_din_r;
        owner_nxt_s     = owner_r;
        ptr_nxt_s       = ptr_r;
        burst_cnt_nxt_s = {BW{1'b0}};
        if (cont_s) begin
            // Regrant under lock leaves the pointer where the first grant put it.
            state_nxt_s     = GRANT;
            gnt_nxt_s       = ONE_HOT0 << owner_r;
            reg_load_nxt_s  = 1'b1;
            reg_din_nxt_s   = wdata[int'(sel_idx_s)*WIDTH +: WIDTH];
            burst_cnt_nxt_s = burst_cnt_r + BW'(1);
        end else if (found_s) begin
            state_nxt_s     = GRANT;
            gnt_nxt_s       = ONE_HOT0 << winner_s;
            reg_load_nxt_s  = 1'b1;
            reg_din_nxt_s   = wdata[int'(sel_idx_s)*WIDTH +: WIDTH];
            owner_nxt_s     = winner_s;
            ptr_nxt_s       = IW'((int'(winner_s) + 1) % NREQ);
            burst_cnt_nxt_s = {BW{1'b0}};
        end else begin
            state_nxt_s     = IDLE;
            burst_cnt_nxt_s = {BW{1'b0}};
        end
    end

    // State and output registers; reset drops reg_load without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= {NREQ{1'b0}};
            reg_load_r  <= 1'b0;
            reg_din_r   <= {WIDTH{1'b0}};
            owner_r     <= {IW{1'b0}};
            ptr_r       <= {IW{1'b0}};
            burst_cnt_r <= {BW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            reg_load_r  <= reg_load_nxt_s;
            reg_din_r   <= reg_din_nxt_s;
            owner_r     <= owner_nxt_s;
            ptr_r       <= ptr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    assign gnt      = gnt_r;
    assign reg_load = reg_load_r;
    assign reg_din  = reg_din_r;
    assign owner    = owner_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector tables,
// hand-written multi-cycle sequences and randomized traffic compared with a
// behavioural arbitration model. A reg16 stand-in captures the DUT writes.
module tb_reg_write_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         lock;
    logic [NREQ*WIDTH-1:0]   wdata;
    logic [NREQ-1:0]         gnt;
    logic                    reg_load;
    logic [WIDTH-1:0]        reg_din;
    logic [1:0]              owner;
    logic [WIDTH-1:0]        reg_q = 16'h0000;

    int total = 0;
    int bad   = 0;

    // model state
    int              m_ptr;
    int              m_owner;
    int              m_burst;
    bit              m_active;
    logic [NREQ-1:0] mg;
    logic [WIDTH-1:0] mdin;
    bit              mload;
    logic [WIDTH-1:0] exp_q = 16'h0000;

    typedef struct {
        logic [NREQ-1:0]  rq;
        logic [NREQ-1:0]  lk;
        logic [NREQ-1:0]  eg;
        logic [WIDTH-1:0] ed;
    } vec_t;
    vec_t tbl [15];

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .reg_load (reg_load),
        .reg_din  (reg_din),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared 16-bit register.
    always @(posedge clk) begin
        if (reg_load) reg_q <= reg_din;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_burst = 0; m_active = 0;
        mg = '0; mdin = '0; mload = 0;
    endtask

    // Arbitration rules: lock continuation first, otherwise the eligible
    // requester closest (cyclically) at or after the pointer.
    task automatic model_update();
        int win;
        int best;
        int d;
        win = -1;
        if (m_active && lock[m_owner] && req[m_owner] && (m_burst < MAX_BURST - 1)) begin
            win = m_owner;
            m_burst++;
        end else begin
            best = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !(m_active && i == m_owner)) begin
                    d = (i - m_ptr + NREQ) % NREQ;
                    if (d < best) begin best = d; win = i; end
                end
            end
            m_burst = 0;
            if (win >= 0) m_ptr = (win + 1) % NREQ;
        end
        if (win >= 0) begin
            m_active = 1; m_owner = win; mg = NREQ'(1 << win);
            mdin = wdata[win*WIDTH +: WIDTH]; mload = 1;
        end else begin
            m_active = 0; mg = '0; mload = 0;
        end
    endtask

    // Advance one clock: model and DUT both consume the current inputs.
    task automatic step();
        if (mload) exp_q = mdin;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string nm);
        check({nm, ".gnt"},   32'(gnt),      32'(mg));
        check({nm, ".load"},  32'(reg_load), 32'(mload));
        check({nm, ".din"},   32'(reg_din),  32'(mdin));
        check({nm, ".owner"}, 32'(owner),    32'(m_owner));
        check({nm, ".q"},     32'(reg_q),    32'(exp_q));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; lock = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; req = '0; lock = '0; wdata = '0;
        model_reset();

        // Reset with all requests high.
        #2;
        rst_n = 1'b0; req = 4'b1111;
        @(posedge clk); #1;
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.load", 32'(reg_load), 32'h0);
        check("rst.din", 32'(reg_din), 32'h0);
        check("rst.owner", 32'(owner), 32'h0);
        req = 4'b0000; rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle.gnt", 32'(gnt), 32'h0);
        end

        // Single requester held high: grant every other cycle.
        req = 4'b0001; wdata = '0; wdata[15:0] = 16'h000F;
        step();
        check("single.gnt1", 32'(gnt), 32'h1);
        check("single.load1", 32'(reg_load), 32'h1);
        check("single.din1", 32'(reg_din), 32'h000F);
        step();
        check("single.gnt2", 32'(gnt), 32'h0);
        check("single.q", 32'(reg_q), 32'h000F);
        step();
        check("single.gnt3", 32'(gnt), 32'h1);
        step();
        check("single.gnt4", 32'(gnt), 32'h0);

        // Vector tables: full contention, then locked burst.
        for (int i = 0; i < 5; i++) tbl[i] = '{4'b1111, 4'b0000, NREQ'(1 << (i % 4)), WIDTH'((i % 4) + 1)};
        for (int i = 5; i < 15; i++) tbl[i] = '{4'b0110, 4'b0010, 4'b0010, 16'h00A1};
        tbl[9].eg  = 4'b0100; tbl[9].ed  = 16'h00A2;
        tbl[14].eg = 4'b0100; tbl[14].ed = 16'h00A2;

        do_reset();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        for (int i = 0; i < 5; i++) begin
            req = tbl[i].rq; lock = tbl[i].lk;
            step();
            check("contend.gnt", 32'(gnt), 32'(tbl[i].eg));
            check("contend.load", 32'(reg_load), 32'h1);
            check("contend.din", 32'(reg_din), 32'(tbl[i].ed));
        end

        do_reset();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'(16'h00A0 + i);
        for (int i = 5; i < 15; i++) begin
            req = tbl[i].rq; lock = tbl[i].lk;
            step();
            check("burst.gnt", 32'(gnt), 32'(tbl[i].eg));
            check("burst.din", 32'(reg_din), 32'(tbl[i].ed));
        end

        // Pointer wrap: winner 2 leaves ptr=3, then search 3,0 picks 0.
        do_reset();
        lock = 4'b0000;
        req = 4'b0100;
        step();
        check("wrap.gnt2", 32'(gnt), 32'h4);
        check("wrap.owner2", 32'(owner), 32'h2);
        req = 4'b0101;
        step();
        check("wrap.gnt0", 32'(gnt), 32'h1);
        check("wrap.owner0", 32'(owner), 32'h0);
        req = 4'b0011;
        step();
        check("wrap.ptr1", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        check("wrap.idle", 32'(gnt), 32'h0);
        check("wrap.hold_owner", 32'(owner), 32'h1);
        check("wrap.hold_din", 32'(reg_din), 32'h00A1);

        // Async reset in the middle of a locked grant.
        req = 4'b0010; lock = 4'b0010;
        step();
        check("areset.gnt_before", 32'(gnt), 32'h2);
        step();
        check("areset.gnt_cont", 32'(gnt), 32'h2);
        if (mload) exp_q = mdin;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset.load", 32'(reg_load), 32'h0);
        check("areset.gnt", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        check("areset.q", 32'(reg_q), 32'(exp_q));
        rst_n = 1'b1; req = 4'b1111; lock = 4'b0000;
        step();
        check("areset.first", 32'(gnt), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req  = NREQ'($urandom_range(0, 15));
            lock = ($urandom_range(0, 1) == 1) ? NREQ'($urandom_range(0, 15)) : 4'b1111;
            for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            step();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
